// File: rtl/mul_ctrl.sv
// mul_ctrl: runs one RV64M multiply at a time through the iterative Booth multiplier and formats the result.
// Optional product-reuse cache is compiled in with YSYX_22051013_MUL_REUSE_EN.
module mul_ctrl #(
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 40
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [DATA_W-1:0] req_op1,
  input  logic [DATA_W-1:0] req_op2,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              err_timeout,
  output logic              mul_valid,
  output logic              mul_flush,
  output logic [1:0]        mul_signed,
  output logic              mulw,
  output logic [DATA_W-1:0] mult_op1,
  output logic [DATA_W-1:0] mult_op2,
  input  logic              mul_out_valid,
  input  logic [DATA_W-1:0] mul_result_hi,
  input  logic [DATA_W-1:0] mul_result_lo
);

  localparam int               CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_MULW   = 3'd4;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_e;

  // Bit 0 marks op1 signed, bit 1 marks op2 signed.
  function automatic logic [1:0] op_signed(input logic [2:0] op);
    logic [1:0] s;
    case (op)
      OP_MUL, OP_MULH, OP_MULW: s = 2'b11;
      OP_MULHSU:                s = 2'b01;
      default:                  s = 2'b00;
    endcase
    return s;
  endfunction

  function automatic logic [DATA_W-1:0] format_result(input logic [2:0]        op,
                                                      input logic [DATA_W-1:0] hi,
                                                      input logic [DATA_W-1:0] lo);
    logic [DATA_W-1:0] r;
    case (op)
      OP_MUL:                       r = lo;
      OP_MULH, OP_MULHSU, OP_MULHU: r = hi;
      OP_MULW:                      r = {{(DATA_W-32){lo[31]}}, lo[31:0]};
      default:                      r = '0;
    endcase
    return r;
  endfunction

  state_e            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [DATA_W-1:0] op1_q, op1_d, op2_q, op2_d;
  logic [DATA_W-1:0] resp_data_q, resp_data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              timeout_hit;
  logic              reuse_hit;
  logic [DATA_W-1:0] reuse_data;

  assign timeout_hit = (state_q == S_WAIT) && !mul_out_valid && (cnt_q == CNT_LAST);

`ifdef YSYX_22051013_MUL_REUSE_EN
  logic [DATA_W-1:0] tag_op1_q, tag_op2_q, tag_hi_q, tag_lo_q;
  logic [1:0]        tag_signed_q;
  logic              tag_mulw_q, tag_valid_q;
  logic              tag_write;

  assign tag_write  = !flush && (state_q == S_WAIT) && mul_out_valid;
  assign reuse_hit  = tag_valid_q && !tag_mulw_q && (req_op <= OP_MULHU) &&
                      (req_op1 == tag_op1_q) && (req_op2 == tag_op2_q) &&
                      (op_signed(req_op) == tag_signed_q);
  assign reuse_data = format_result(req_op, tag_hi_q, tag_lo_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_valid_q <= 1'b0;
    end else if (tag_write) begin
      tag_valid_q <= 1'b1;
    end else if (!flush && timeout_hit) begin
      tag_valid_q <= 1'b0;
    end
  end

  // NOTE: tag payload has no reset; tag_valid_q alone guards it, so the wide registers stay reset-free.
  always_ff @(posedge clk) begin
    if (tag_write) begin
      tag_op1_q    <= op1_q;
      tag_op2_q    <= op2_q;
      tag_signed_q <= op_signed(op_q);
      tag_mulw_q   <= (op_q == OP_MULW);
      tag_hi_q     <= mul_result_hi;
      tag_lo_q     <= mul_result_lo;
    end
  end
`else
  assign reuse_hit  = 1'b0;
  assign reuse_data = '0;
`endif

  // NOTE: every _d gets its hold value first so no path through the case leaves a latch behind.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    resp_data_d = resp_data_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            op_d  = req_op;
            op1_d = req_op1;
            op2_d = req_op2;
            if (req_op > OP_MULW) begin
              state_d     = S_DONE;
              resp_data_d = '0;
            end else if (reuse_hit) begin
              state_d     = S_DONE;
              resp_data_d = reuse_data;
            end else begin
              state_d = S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
        S_WAIT: begin
          if (mul_out_valid) begin
            state_d     = S_DONE;
            resp_data_d = format_result(op_q, mul_result_hi, mul_result_lo);
          end else if (timeout_hit) begin
            state_d     = S_DONE;
            resp_data_d = '0;
            err_d       = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          if (resp_ready) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: state registers use <= so every flop samples the pre-edge values of its peers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      op1_q       <= '0;
      op2_q       <= '0;
      resp_data_q <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      resp_data_q <= resp_data_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
    end
  end

  assign req_ready   = (state_q == S_IDLE) && !flush;
  assign resp_valid  = (state_q == S_DONE);
  assign resp_data   = resp_data_q;
  assign err_timeout = err_q;
  assign mul_valid   = (state_q == S_ISSUE);
  assign mul_flush   = (flush && ((state_q == S_ISSUE) || (state_q == S_WAIT))) || timeout_hit;
  assign mul_signed  = op_signed(op_q);
  assign mulw        = (op_q == OP_MULW);
  assign mult_op1    = op1_q;
  assign mult_op2    = op2_q;

endmodule

// File: doc/mul_ctrl.md
Name: mul_ctrl

Overview:
- Sequencing controller between the EX stage and the 2-bit Booth iterative multiplier.
- Accepts one RV64M multiply op at a time: MUL, MULH, MULHSU, MULHU, MULW.
- Drives the multiplier's start/signedness/word controls, waits for its data-dependent completion, then selects and formats the 64-bit result.
- Holds the result until EX accepts it, and handles pipeline flush and a completion watchdog.

Parameters:
- DATA_W, 64, operand/result width.
- TIMEOUT, 40, max cycles in WAIT before watchdog abort.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  pipeline flush; kills the in-flight op.
- req_valid  in  1  EX has an op.
- req_ready  out  1  controller accepts an op.
- req_op  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 MULW; 5-7 reserved.
- req_op1  in  DATA_W  rs1 value.
- req_op2  in  DATA_W  rs2 value.
- resp_valid  out  1  result available.
- resp_ready  in  1  EX takes result.
- resp_data  out  DATA_W  formatted result.
- err_timeout  out  1  sticky watchdog flag.
- mul_valid  out  1  start pulse to multiplier.
- mul_flush  out  1  flush to multiplier.
- mul_signed  out  2  [0] op1 signed, [1] op2 signed.
- mulw  out  1  word-mode to multiplier.
- mult_op1  out  DATA_W  latched op1.
- mult_op2  out  DATA_W  latched op2.
- mul_out_valid  in  1  multiplier done.
- mul_result_hi  in  DATA_W  product [127:64].
- mul_result_lo  in  DATA_W  product [63:0].

Behaviour:
- Reset: state IDLE; req_ready=1; resp_valid=0; resp_data=0; mul_valid=0; mul_flush=0; err_timeout=0; operand/op registers=0; watchdog counter=0.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - req_ready = ~flush.
  - On req_valid & req_ready: latch op/op1/op2 → ISSUE.
- ISSUE:
  - mul_valid=1 for exactly this one cycle; mult_op1/op2 driven from latches.
  - Signedness: MUL 2'b11, MULH 2'b11, MULHSU 2'b01, MULHU 2'b00, MULW 2'b11 with mulw=1.
  - Next state WAIT; counter cleared.
- WAIT:
  - mul_out_valid may assert in the first WAIT cycle (op2 zero); it must be honoured there.
  - On mul_out_valid: register the formatted result → DONE.
  - Formatting: MUL = lo; MULH/MULHSU/MULHU = hi; MULW = sign-extend lo[31:0].
  - Counter increments each WAIT cycle.
  - If counter reaches TIMEOUT without mul_out_valid: pulse mul_flush 1 cycle, set err_timeout, resp_data=0 → DONE.
- DONE:
  - resp_valid=1; resp_data stable until resp_valid & resp_ready → IDLE.
  - req_ready=0 in DONE, so there is no back-to-back overlap.
  - Result latency: accept at cycle T, mul_valid at T+1, resp_valid the cycle after mul_out_valid.
- mult_op1/op2/mul_signed/mulw hold latched values outside ISSUE; the multiplier samples them only on mul_valid.
- Flush (any state, highest priority):
  - Next state IDLE; resp_valid drops next cycle; no response for the killed op.
  - mul_flush=1 in the flush cycle when state is ISSUE or WAIT.
  - Flush coincident with req_valid in IDLE: request not accepted.
  - Flush coincident with resp_ready in DONE: flush wins, treated as not delivered.
- Reserved req_op (5-7): accepted, no issue; DONE next cycle with resp_data=0.
- err_timeout is cleared only by rst.
- rst mid-operation: all state returns to reset values in the next cycle; mul_valid is never left asserted.

Optional Feature:
- Macro: YSYX_22051013_MUL_REUSE_EN.
- Enabled:
  - Controller keeps the last completed 128-bit product with a tag {op1, op2, mul_signed, mulw, tag_valid}.
  - On accept in IDLE with a non-MULW, non-reserved op whose op1/op2/mul_signed match the tag and tag_valid=1: skip ISSUE/WAIT and go directly to DONE next cycle with the formatted cached result. mul_valid stays 0.
  - Tag is written on every normal completion.
  - Tag is invalidated by rst and by watchdog timeout; flush does not invalidate it.
- Disabled: no tag storage; every op goes through ISSUE/WAIT.

Test Plan:
- MUL op1=3, op2=0xFFFFFFFFFFFFFFFB (-5) → one mul_valid pulse, mul_signed=2'b11; resp_data=0xFFFFFFFFFFFFFFF1.
- MULHU op1=op2=0xFFFFFFFFFFFFFFFF → mul_signed=2'b00; resp_data=0xFFFFFFFFFFFFFFFE.
- MULHSU op1=0xFFFFFFFFFFFFFFFF, op2=2 → mul_signed=2'b01; resp_data=0xFFFFFFFFFFFFFFFF.
- MULW op1=0x7FFFFFFF, op2=2 → mulw=1; resp_data=0xFFFFFFFFFFFFFFFE. Then hold resp_ready=0 for 5 cycles → resp_valid and resp_data stable, req_ready=0.
- Flush 3 cycles into WAIT → mul_flush pulses once; no resp_valid; req_ready=1 the next cycle. Separately, stub mul_out_valid=0 → err_timeout=1 after 40 WAIT cycles; resp_data=0.
- With YSYX_22051013_MUL_REUSE_EN: MULH(a,b) then MUL(a,b) with a=0x123456789, b=0x1000 → second op has no mul_valid; resp_valid 1 cycle after accept; resp_data=0x123456789000.
